// File: rtl/ir_cash_fill_pkg.sv
// Shared widths and FSM state encoding for the instruction cache fill block.
package ir_cash_fill_pkg;

  localparam int CF_DATA_WIDTH     = 8;
  localparam int CF_IR_ADDR_WIDTH  = 8;
  localparam int CF_MEM_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    CF_IDLE  = 2'd0,
    CF_FILL  = 2'd1,
    CF_READY = 2'd2
  } cf_state_e;

endpackage

// File: rtl/ir_cash_ram.sv
// Single-clock instruction RAM: one synchronous write port, one registered read port.
module ir_cash_ram
  import ir_cash_fill_pkg::*;
#(
  parameter int DATA_WIDTH = CF_DATA_WIDTH,
  parameter int ADDR_WIDTH = CF_IR_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read register only loads on a read strobe, so it holds the last word read.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ir_cash_fill.sv
// Instruction cache: preloads 2**IR_ADDR_WIDTH words from memory, then serves
// decoder reads with one cycle of latency. A reload in READY refills from a new base.
module ir_cash_fill
  import ir_cash_fill_pkg::*;
#(
  parameter int                          DATA_WIDTH     = CF_DATA_WIDTH,
  parameter int                          IR_ADDR_WIDTH  = CF_IR_ADDR_WIDTH,
  parameter int                          MEM_ADDR_WIDTH = CF_MEM_ADDR_WIDTH,
  parameter logic [MEM_ADDR_WIDTH-1:0]   BASE_ADDR      = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IR_ADDR_WIDTH-1:0]  i_irp,
  input  logic                      i_ren,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_data_valid,
  output logic                      o_cash_init_done,
  input  logic                      i_reload,
  input  logic [MEM_ADDR_WIDTH-1:0] i_base,
  output logic                      o_mem_req,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                      i_mem_ack,
  input  logic [DATA_WIDTH-1:0]     i_mem_data
);

  localparam int                CNT_W    = IR_ADDR_WIDTH + 1;
  localparam int                DEPTH    = 2**IR_ADDR_WIDTH;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DEPTH - 1);

  cf_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          fill_cnt_q, fill_cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic                      rvalid_q;
  logic                      rd_seen_q;
  logic                      fill_ack;
  logic                      rd_en;
  logic [DATA_WIDTH-1:0]     ram_rdata;

  assign fill_ack = (state_q == CF_FILL) && i_mem_ack;
  // A reload in the same cycle as a read takes priority and drops the read.
  assign rd_en    = (state_q == CF_READY) && i_ren && !i_reload;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    base_d     = base_q;
    unique case (state_q)
      CF_IDLE: begin
        state_d    = CF_FILL;
        fill_cnt_d = '0;
      end
      CF_FILL: begin
        if (fill_ack) begin
          fill_cnt_d = fill_cnt_q + CNT_W'(1);
          if (fill_cnt_q == LAST_IDX) state_d = CF_READY;
        end
      end
      CF_READY: begin
        if (i_reload) begin
          state_d    = CF_FILL;
          fill_cnt_d = '0;
          base_d     = i_base;
        end
      end
      default: state_d = CF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CF_IDLE;
      fill_cnt_q <= '0;
      base_q     <= BASE_ADDR;
      rvalid_q   <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      base_q     <= base_d;
      rvalid_q   <= rd_en;
      rd_seen_q  <= rd_seen_q | rd_en;
    end
  end

  ir_cash_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (IR_ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (fill_ack),
    .waddr_i (fill_cnt_q[IR_ADDR_WIDTH-1:0]),
    .wdata_i (i_mem_data),
    .re_i    (rd_en),
    .raddr_i (i_irp),
    .rdata_o (ram_rdata)
  );

  // The RAM read register is not reset; present zero until the first real read.
  assign o_data           = rd_seen_q ? ram_rdata : '0;
  assign o_data_valid     = rvalid_q;
  assign o_cash_init_done = (state_q == CF_READY);
  assign o_mem_req        = (state_q == CF_FILL);
  assign o_mem_addr       = base_q + MEM_ADDR_WIDTH'(fill_cnt_q);

endmodule

// File: tb/tb_ir_cash_fill.sv
// Scoreboard bench for ir_cash_fill: memory responder model, read queue, directed scenarios.
module tb_ir_cash_fill;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i_irp;
  logic        i_ren;
  logic [7:0]  o_data;
  logic        o_data_valid;
  logic        o_cash_init_done;
  logic        i_reload;
  logic [15:0] i_base;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack;
  logic [7:0]  i_mem_data;

  ir_cash_fill dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_irp            (i_irp),
    .i_ren            (i_ren),
    .o_data           (o_data),
    .o_data_valid     (o_data_valid),
    .o_cash_init_done (o_cash_init_done),
    .i_reload         (i_reload),
    .i_base           (i_base),
    .o_mem_req        (o_mem_req),
    .o_mem_addr       (o_mem_addr),
    .i_mem_ack        (i_mem_ack),
    .i_mem_data       (i_mem_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks after ack_delay wait cycles, data = addr[7:0],
  // and checks every requested address against exp_base + word index.
  int          ack_delay     = 0;
  logic [15:0] exp_base      = 16'h0;
  int          fill_idx      = 0;
  int          last_ack_edge = 0;
  int          wait_cnt      = 0;
  logic        prev_req      = 1'b0;
  logic        resp_ack      = 1'b0;
  logic [7:0]  resp_data     = 8'h0;
  logic        stray_ack     = 1'b0;

  assign i_mem_ack  = resp_ack | stray_ack;
  assign i_mem_data = resp_data;

  initial begin
    logic [15:0] ea;
    forever begin
      @(posedge clk); #1;
      if (o_mem_req) begin
        if (!prev_req) begin
          fill_idx = 0;
          wait_cnt = 0;
        end
        ea = exp_base + 16'(fill_idx);
        check("mem_addr", o_mem_addr, ea);
        if (wait_cnt >= ack_delay) begin
          resp_ack      = 1'b1;
          resp_data     = o_mem_addr[7:0];
          fill_idx      = fill_idx + 1;
          last_ack_edge = cyc + 1;
          wait_cnt      = 0;
        end else begin
          resp_ack = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        resp_ack = 1'b0;
        wait_cnt = 0;
      end
      prev_req = o_mem_req;
    end
  end

  // Read scoreboard monitor
  logic [7:0] exp_q [$];

  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk); #1;
      if (o_data_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", o_data, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    i_ren = 1'b1;
    i_irp = a;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic rd_finish(input string name);
    i_ren = 1'b0;
    tick();
    tick();
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_done(input string name, input int max);
    int n;
    n = 0;
    while (!o_cash_init_done && n < max) begin
      tick();
      n++;
    end
    if (!o_cash_init_done) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_done_edge"}, cyc, last_ack_edge);
      check({name, "_acks"}, fill_idx, DEPTH);
    end
  endtask

  task automatic wait_words(input int words);
    int n;
    n = 0;
    while (fill_idx < words && n < 2000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    i_irp    = '0;
    i_ren    = 1'b0;
    i_reload = 1'b0;
    i_base   = '0;

    repeat (3) @(posedge clk);
    #2;
    check("rst_req", o_mem_req, 0);
    check("rst_done", o_cash_init_done, 0);
    check("rst_valid", o_data_valid, 0);
    check("rst_data", o_data, 0);
    rst_n = 1'b1;

    // Initial fill, ack every cycle
    wait_done("fill0", 2000);

    // Back-to-back reads
    rd(8'h05, 8'h05);
    rd(8'h06, 8'h06);
    rd(8'h07, 8'h07);
    rd_finish("rd0");
    check("valid_low_idle", o_data_valid, 0);
    check("data_hold", o_data, 8'h07);

    // Refill from base 0 with 3 wait cycles per word
    ack_delay = 3;
    exp_base  = 16'h0000;
    i_reload  = 1'b1;
    i_base    = 16'h0000;
    tick();
    i_reload = 1'b0;
    check("reload_done_drop", o_cash_init_done, 0);
    wait_words(10);
    i_ren = 1'b1;
    i_irp = 8'h05;
    tick();
    i_ren = 1'b0;
    check("fill_read_dropped", o_data_valid, 0);
    i_reload = 1'b1;
    i_base   = 16'h1234;
    tick();
    i_reload = 1'b0;
    wait_done("fill_d3", 3000);
    rd(8'h05, 8'h05);
    rd(8'h00, 8'h00);
    rd(8'hFF, 8'hFF);
    rd_finish("rd1");

    // Reload with wrapping base, colliding with a read
    ack_delay = 0;
    exp_base  = 16'hFFFE;
    i_reload  = 1'b1;
    i_base    = 16'hFFFE;
    i_ren     = 1'b1;
    i_irp     = 8'h10;
    tick();
    i_reload = 1'b0;
    i_ren    = 1'b0;
    check("wrap_done_drop", o_cash_init_done, 0);
    check("wrap_read_dropped", o_data_valid, 0);
    wait_done("fill_wrap", 2000);
    rd(8'h00, 8'hFE);
    rd(8'h01, 8'hFF);
    rd(8'h02, 8'h00);
    rd(8'hFF, 8'hFD);
    rd_finish("rd2");

    // Reset in the middle of a fill
    exp_base = 16'h0000;
    i_reload = 1'b1;
    i_base   = 16'h0000;
    tick();
    i_reload = 1'b0;
    wait_words(100);
    tick();
    check("midfill_addr", o_mem_addr, 16'd100);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_req", o_mem_req, 0);
    check("midrst_done", o_cash_init_done, 0);
    check("midrst_data", o_data, 0);
    tick();
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    check("midrst_req_held", o_mem_req, 0);
    tick();
    rst_n = 1'b1;
    wait_done("refill", 2000);
    rd(8'd200, 8'd200);
    rd(8'd99, 8'd99);
    rd(8'd0, 8'd0);
    rd_finish("rd3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
